// File: rtl/can_reg_pkg.sv
// Shared register map for the CAN controller register window.
// Holds the addresses, bit positions, write masks and reset values used by the window and the interrupt latch.
package can_reg_pkg;

    // Register addresses
    localparam logic [7:0] ADDR_MODE     = 8'h00;
    localparam logic [7:0] ADDR_CMD      = 8'h01;
    localparam logic [7:0] ADDR_STATUS   = 8'h02;
    localparam logic [7:0] ADDR_INT      = 8'h03;
    localparam logic [7:0] ADDR_INT_EN   = 8'h04;
    localparam logic [7:0] ADDR_WIN_BASE = 8'h10;
    localparam logic [7:0] ADDR_WIN_LAST = 8'h1C;

    // MODE bits
    localparam int MODE_RM_BIT  = 0;
    localparam int MODE_LOM_BIT = 1;
    localparam logic [7:0] MODE_WMASK = 8'h03;

    // COMMAND bits
    localparam int CMD_RRB_BIT = 2;  // release receive buffer
    localparam int CMD_CDO_BIT = 3;  // clear data overrun

    // INTERRUPT / INT_EN bits
    localparam int INT_RI_BIT  = 0;
    localparam int INT_EI_BIT  = 1;
    localparam int INT_DOI_BIT = 3;
    localparam logic [7:0] INT_MASK = 8'h0B;

    // Reset values and fixed read values
    localparam logic [7:0] MODE_RST     = 8'h01;
    localparam logic [7:0] INT_EN_RST   = 8'h00;
    localparam logic [7:0] INT_RST      = 8'h00;
    localparam logic [7:0] DOUT_RST     = 8'h00;
    localparam logic [7:0] CMD_READ_VAL = 8'hFF;
    localparam logic [7:0] WIN_RM_VAL   = 8'hFF;
    localparam logic [7:0] UNMAPPED_VAL = 8'h00;

    typedef enum logic [2:0] {
        SEL_MODE,
        SEL_CMD,
        SEL_STATUS,
        SEL_INT,
        SEL_INT_EN,
        SEL_WIN,
        SEL_NONE
    } reg_sel_e;

    // Classify a bus address into the register it selects
    function automatic reg_sel_e decode_addr(input logic [7:0] addr);
        reg_sel_e sel;
        sel = SEL_NONE;
        if (addr == ADDR_MODE) begin
            sel = SEL_MODE;
        end else if (addr == ADDR_CMD) begin
            sel = SEL_CMD;
        end else if (addr == ADDR_STATUS) begin
            sel = SEL_STATUS;
        end else if (addr == ADDR_INT) begin
            sel = SEL_INT;
        end else if (addr == ADDR_INT_EN) begin
            sel = SEL_INT_EN;
        end else if (addr >= ADDR_WIN_BASE && addr <= ADDR_WIN_LAST) begin
            sel = SEL_WIN;
        end
        return sel;
    endfunction

endpackage

// File: rtl/can_irq_latch.sv
// Interrupt flag latch: sticky flags set by gated event pulses, cleared on read
// or held clear while the controller is in reset mode. irq_o is registered.
module can_irq_latch
    import can_reg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       force_clr_i,  // hold all flags at zero, ignore set pulses
    input  logic       rd_clr_i,     // INTERRUPT register read this cycle
    input  logic [7:0] set_i,        // event pulses at their INTERRUPT bit positions
    input  logic [7:0] en_i,         // INT_EN register
    output logic [7:0] int_o,
    output logic       irq_o
);

    logic [7:0] int_q;
    logic [7:0] int_d;
    logic       irq_q;

    // A set pulse coincident with the clearing read wins, so the event is not lost
    for (genvar gi = 0; gi < 8; gi++) begin : g_bit
        assign int_d[gi] = INT_MASK[gi] & ~force_clr_i &
                           ((int_q[gi] & ~rd_clr_i) | (set_i[gi] & en_i[gi]));
    end

    // Flag register and registered interrupt request
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            int_q <= INT_RST;
            irq_q <= 1'b0;
        end else begin
            int_q <= int_d;
            irq_q <= |int_d;
        end
    end

    assign int_o = int_q;
    assign irq_o = irq_q;

endmodule

// File: rtl/can_reg_window.sv
// 8051-facing register window of the CAN controller: MODE, COMMAND, STATUS,
// INTERRUPT, INT_EN and a 13-byte receive-buffer window, with registered read data.
module can_reg_window
    import can_reg_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       reg_re_i,
    input  logic       reg_we_i,
    input  logic [7:0] reg_addr_i,
    input  logic [7:0] reg_data_in_i,
    output logic [7:0] reg_data_out_o,
    output logic [3:0] rx_buf_addr_o,
    input  logic [7:0] rx_buf_data_i,
    input  logic       rx_valid_i,
    input  logic       overrun_i,
    input  logic       bus_off_i,
    input  logic       rx_irq_set_i,
    input  logic       err_irq_set_i,
    input  logic       ovr_irq_set_i,
    output logic       reset_mode_o,
    output logic       listen_only_o,
    output logic       release_buf_o,
    output logic       clr_overrun_o,
    output logic       irq_o
);

    reg_sel_e   sel;
    logic       wr_fire;
    logic       rd_fire;

    logic [7:0] mode_q,   mode_d;
    logic [7:0] int_en_q, int_en_d;
    logic [7:0] dout_q,   dout_d;
    logic       rel_q,    rel_d;
    logic       cdo_q,    cdo_d;

    logic [7:0] rd_val;
    logic [7:0] int_val;
    logic [7:0] irq_set;
    logic       irq_force_clr;

    assign sel     = decode_addr(reg_addr_i);
    // A simultaneous write takes priority and the read is dropped
    assign wr_fire = reg_we_i;
    assign rd_fire = reg_re_i & ~reg_we_i;

    // Window index follows the address so the buffer byte is ready at the read edge
    assign rx_buf_addr_o = (!rst_i && sel == SEL_WIN) ? reg_addr_i[3:0] : 4'h0;

    // Writable register next-state and command pulse generation
    always_comb begin
        mode_d   = mode_q;
        int_en_d = int_en_q;
        rel_d    = 1'b0;
        cdo_d    = 1'b0;
        if (wr_fire) begin
            case (sel)
                SEL_MODE:   mode_d   = reg_data_in_i & MODE_WMASK;
                SEL_INT_EN: int_en_d = reg_data_in_i & INT_MASK;
                SEL_CMD: begin
                    // Commands are only honoured in operating mode
                    rel_d = reg_data_in_i[CMD_RRB_BIT] & ~mode_q[MODE_RM_BIT];
                    cdo_d = reg_data_in_i[CMD_CDO_BIT] & ~mode_q[MODE_RM_BIT];
                end
                default: ;
            endcase
        end
    end

    // Read-data selection from the current register state and status levels
    always_comb begin
        rd_val = UNMAPPED_VAL;
        case (sel)
            SEL_MODE:   rd_val = mode_q;
            SEL_CMD:    rd_val = CMD_READ_VAL;
            SEL_STATUS: rd_val = {bus_off_i, 5'b0, overrun_i, rx_valid_i};
            SEL_INT:    rd_val = int_val;
            SEL_INT_EN: rd_val = int_en_q;
            SEL_WIN:    rd_val = mode_q[MODE_RM_BIT] ? WIN_RM_VAL : rx_buf_data_i;
            default:    rd_val = UNMAPPED_VAL;
        endcase
        dout_d = rd_fire ? rd_val : dout_q;
    end

    // Register state; async reset also aborts any pending command pulse
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mode_q   <= MODE_RST;
            int_en_q <= INT_EN_RST;
            dout_q   <= DOUT_RST;
            rel_q    <= 1'b0;
            cdo_q    <= 1'b0;
        end else begin
            mode_q   <= mode_d;
            int_en_q <= int_en_d;
            dout_q   <= dout_d;
            rel_q    <= rel_d;
            cdo_q    <= cdo_d;
        end
    end

    // Event pulses placed at their INTERRUPT bit positions
    always_comb begin
        irq_set              = 8'h00;
        irq_set[INT_RI_BIT]  = rx_irq_set_i;
        irq_set[INT_EI_BIT]  = err_irq_set_i;
        irq_set[INT_DOI_BIT] = ovr_irq_set_i;
    end

    // Flags stay clear across any edge where reset mode is active before or after
    assign irq_force_clr = mode_q[MODE_RM_BIT] | mode_d[MODE_RM_BIT];

    can_irq_latch u_irq_latch (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .force_clr_i (irq_force_clr),
        .rd_clr_i    (rd_fire && sel == SEL_INT),
        .set_i       (irq_set),
        .en_i        (int_en_q),
        .int_o       (int_val),
        .irq_o       (irq_o)
    );

    assign reg_data_out_o = dout_q;
    assign reset_mode_o   = mode_q[MODE_RM_BIT];
    assign listen_only_o  = mode_q[MODE_LOM_BIT];
    assign release_buf_o  = rel_q;
    assign clr_overrun_o  = cdo_q;

endmodule
